// File: rtl/can_reg_bank_asyn.sv
// Addressed bank of DEPTH x WIDTH registers with per-bit R/W, W1C and clear-on-read
// modes, hardware set inputs, per-register write lock and a registered read port.
module can_reg_bank_asyn #(
    parameter int unsigned            WIDTH       = 8,
    parameter int unsigned            DEPTH       = 4,
    parameter int unsigned            ADDR_W      = 2,
    parameter logic [DEPTH*WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [DEPTH*WIDTH-1:0] W1C_MASK    = '0,
    parameter logic [DEPTH*WIDTH-1:0] ROC_MASK    = '0,
    parameter logic [DEPTH-1:0]       LOCK_MASK   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   we,
    input  logic                   re,
    input  logic                   unlock,
    input  logic [DEPTH*WIDTH-1:0] hw_set,
    output logic [WIDTH-1:0]       rdata,
    output logic                   rvalid,
    output logic                   wr_err,
    output logic [DEPTH*WIDTH-1:0] data_out
);

    logic [DEPTH*WIDTH-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]       wr_hit, rd_hit;
    logic [WIDTH-1:0]       rd_word;
    logic [WIDTH-1:0]       cur, w1c, roc, clr, wr_val;
    logic                   wr_err_d;

    // Address decode; an out-of-range addr matches no register, so reads return 0
    // and writes are rejected.
    always_comb begin
        wr_hit  = '0;
        rd_hit  = '0;
        rd_word = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (32'(addr) == i) begin
                wr_hit[i] = we && (!LOCK_MASK[i] || unlock);
                rd_hit[i] = re;
                rd_word   = regs_q[i*WIDTH +: WIDTH];
            end
        end
        wr_err_d = we && !(|wr_hit);
    end

    // Per-bit next state: hw_set beats any clear, clears beat plain writes.
    always_comb begin
        regs_d = regs_q;
        cur    = '0;
        w1c    = '0;
        roc    = '0;
        clr    = '0;
        wr_val = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cur    = regs_q[i*WIDTH +: WIDTH];
            w1c    = W1C_MASK[i*WIDTH +: WIDTH];
            roc    = ROC_MASK[i*WIDTH +: WIDTH];
            clr    = (wr_hit[i] ? (w1c & wdata) : '0) | (rd_hit[i] ? roc : '0);
            wr_val = wr_hit[i] ? ((cur & w1c) | (wdata & ~w1c)) : cur;
            regs_d[i*WIDTH +: WIDTH] = (wr_val & ~clr) | hw_set[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= RESET_VALUE;
            rdata  <= '0;
            rvalid <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            regs_q <= regs_d;
            rvalid <= re;
            wr_err <= wr_err_d;
            if (re) begin
                rdata <= rd_word;
            end
        end
    end

    assign data_out = regs_q;

endmodule
